rr_onehot_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 37 +++
 rtl/rr_onehot_arbiter.sv | 103 ++++++++++
 tb/tb_rr_onehot_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types, defaults and helpers for the round-robin one-hot arbiter.
package arb_pkg;

  localparam int ARB_NUM_REQ  = 5;
  localparam int ARB_MAX_HOLD = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Requester that gets top priority once `owner` gives up the grant.
  function automatic int next_ptr(input int owner, input int n);
    return (owner >= n - 1) ? 0 : owner + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or above ptr, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [ID_W-1:0]    pick_id
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] masked;
  logic                 found;

  // The upper copy of req supplies the wrapped-around candidates below ptr.
  always_comb begin
    dbl     = {req, req};
    masked  = '0;
    pick    = '0;
    pick_id = '0;
    found   = 1'b0;
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr));
    end
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      if (!found && masked[i]) begin
        found   = 1'b1;
        pick_id = ID_W'((i < NUM_REQ) ? i : i - NUM_REQ);
        pick    = NUM_REQ'(1) << ((i < NUM_REQ) ? i : i - NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered one-hot-or-zero grant, bounded hold time
// and a mandatory idle cycle between owners.
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = ARB_NUM_REQ,
  parameter int MAX_HOLD = ARB_MAX_HOLD,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout
);

  localparam int CNT_W = $clog2(MAX_HOLD + 2);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    ptr, ptr_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_nxt;
  logic [NUM_REQ-1:0] gnt_nxt, pick;
  logic [ID_W-1:0]    gnt_id_nxt, pick_id;
  logic               busy_nxt, timeout_nxt;
  logic               owner_req, expired, release_gnt;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .pick    (pick),
    .pick_id (pick_id)
  );

  // gnt is one-hot while in GRANT, so masking req with it isolates the owner's bit.
  assign owner_req   = |(req & gnt);
  assign expired     = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIM);
  assign release_gnt = !owner_req || !en || expired;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt;
    gnt_id_nxt  = gnt_id;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && |req) begin
          state_nxt  = GRANT;
          gnt_nxt    = pick;
          gnt_id_nxt = pick_id;
          busy_nxt   = 1'b1;
          hold_nxt   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (release_gnt) begin
          // A dropped request or revoked enable outranks expiry, so no timeout pulse then.
          timeout_nxt = owner_req && en;
          state_nxt   = IDLE;
          ptr_nxt     = ID_W'(next_ptr(int'(gnt_id), NUM_REQ));
          hold_nxt    = '0;
          gnt_nxt     = '0;
          gnt_id_nxt  = '0;
          busy_nxt    = 1'b0;
        end else if (hold_cnt != CNT_MAX) begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scoreboard bench for rr_onehot_arbiter: directed scenarios plus random traffic vs. a behavioural model.
module tb_rr_onehot_arbiter;

  localparam int N  = 5;
  localparam int MH = 4;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          timeout;

  rr_onehot_arbiter #(
    .NUM_REQ  (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [IW-1:0] id;
    logic          busy;
    logic          to;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  bit   started = 1'b0;

  // Behavioural model: owner index (-1 = none), priority pointer, cycles held so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  task automatic model_step(input bit r, input bit e, input logic [N-1:0] rq, output exp_t x);
    bit owner_bit;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (e && rq != '0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (((rq >> c) & N'(1)) != '0) begin
            m_owner = c;
            break;
          end
        end
        m_hold = 1;
      end
    end else begin
      owner_bit = ((rq >> m_owner) & N'(1)) != '0;
      if (!owner_bit || !e) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_to = 1'b0;
      end else if (MH != 0 && m_hold >= MH) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_to = 1'b1;
      end else begin
        m_hold++;
      end
    end
    x.gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    x.id   = (m_owner >= 0) ? IW'(m_owner) : '0;
    x.busy = (m_owner >= 0);
    x.to   = m_to;
  endtask

  task automatic cyc(input bit r, input bit e, input logic [N-1:0] rq);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; req = rq;
    model_step(r, e, rq, x);
    q.push_back(x);
    started = 1'b1;
    @(posedge clk);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output, compare it to the oldest expectation.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("gnt",     int'(gnt),     int'(x.gnt));
      chk("gnt_id",  int'(gnt_id),  int'(x.id));
      chk("busy",    int'(busy),    int'(x.busy));
      chk("timeout", int'(timeout), int'(x.to));
    end
    if (started) begin
      chk("onehot0_gnt",     int'($onehot0(gnt)),       1);
      chk("busy_eq_or_gnt",  int'(busy == (|gnt)),      1);
      chk("timeout_no_gnt",  int'(!(timeout && |gnt)),  1);
    end
  end

  a_onehot0: assert property (@(posedge clk) disable iff (!started) $onehot0(gnt))
    else begin
      errors++;
      $display("FAIL onehot0_assert at %0t: gnt=%b", $time, gnt);
    end

  initial begin
    logic [N-1:0] rq;
    bit           e;
    bit           r;

    // Reset held with all requests pending, then full rotation under MAX_HOLD expiry.
    cyc(1, 1, 5'b11111);
    cyc(1, 1, 5'b11111);
    repeat (31) cyc(0, 1, 5'b11111);

    // Single request on requester 2, then its release leaves ptr at 3.
    cyc(1, 0, 5'b00000);
    repeat (3) cyc(0, 1, 5'b00100);
    repeat (2) cyc(0, 1, 5'b00000);

    // Fairness after the pointer moved past 2: requester 0 wins over 2.
    repeat (3) cyc(0, 1, 5'b00101);
    repeat (2) cyc(0, 1, 5'b00000);

    // Enable revocation and re-grant.
    repeat (2) cyc(0, 1, 5'b01000);
    repeat (3) cyc(0, 0, 5'b01000);
    repeat (3) cyc(0, 1, 5'b01000);
    repeat (2) cyc(0, 1, 5'b00000);

    // Reset in the middle of a grant.
    repeat (2) cyc(0, 1, 5'b01000);
    cyc(1, 1, 5'b01000);
    repeat (2) cyc(0, 1, 5'b10001);

    // Random traffic: sticky request vectors so grants live long enough to expire.
    rq = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom);
      e = ($urandom_range(0, 7) != 0);
      r = ($urandom_range(0, 49) == 0);
      cyc(r, e, rq);
    end
    cyc(0, 1, 5'b00000);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
